// File: rtl/clock_display_if.sv
// Bundle between the time-of-day counter/set controls and the four seven-segment digits.
interface clock_display_if;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic       set;
    logic [1:0] sethms;
    logic       pageSel;
    logic [6:0] hex3;
    logic [6:0] hex2;
    logic [6:0] hex1;
    logic [6:0] hex0;

    modport master (output hour, min, sec, set, sethms, pageSel,
                    input  hex3, hex2, hex1, hex0);
    modport slave  (input  hour, min, sec, set, sethms, pageSel,
                    output hex3, hex2, hex1, hex0);
endinterface

// File: rtl/clock_display.sv
// Four-digit HH:MM / MM:SS display: synchronises counter values, converts them to BCD with a
// free-running double-dabble loop and drives active-low segments with set-mode blinking.
module clock_display #(
    parameter int BLINK_HALF = 12500000
) (
    input  logic           clk,
    input  logic           resetN,
    clock_display_if.slave disp
);
    localparam int         CW        = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef struct packed {
        logic [4:0] hour;
        logic [5:0] min;
        logic [5:0] sec;
        logic       set;
        logic [1:0] sethms;
        logic       page_sel;
    } word_t;

    typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

    word_t          in_word;
    word_t          sync1_reg, sync2_reg, prev_reg;
    word_t          snap_reg, snap_next;
    state_t         state_reg, state_next;
    logic [2:0]     conv_cnt_reg, conv_cnt_next;
    logic [5:0]     bin_l_reg, bin_l_next, bin_r_reg, bin_r_next;
    logic [7:0]     bcd_l_reg, bcd_l_next, bcd_r_reg, bcd_r_next;
    logic [13:0]    shift_l, shift_r;
    logic [CW-1:0]  blink_cnt_reg, blink_cnt_next;
    logic           hidden_reg, hidden_next;
    logic [3:0][6:0] hex_reg, hex_next;
    logic           stable, set_rise;
    logic           left_bad, right_bad, left_blank, right_blank;

    function automatic logic [7:0] dabble_adj(input logic [7:0] b);
        logic [7:0] r;
        r = b;
        if (r[3:0] >= 4'd5) r[3:0] = r[3:0] + 4'd3;
        if (r[7:4] >= 4'd5) r[7:4] = r[7:4] + 4'd3;
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    function automatic logic [5:0] left_bin(input word_t w);
        return w.page_sel ? w.min : {1'b0, w.hour};
    endfunction

    function automatic logic [5:0] right_bin(input word_t w);
        return w.page_sel ? w.sec : w.min;
    endfunction

    assign in_word  = '{hour: disp.hour, min: disp.min, sec: disp.sec, set: disp.set,
                        sethms: disp.sethms, page_sel: disp.pageSel};
    assign stable   = (sync2_reg == prev_reg);
    assign set_rise = sync2_reg.set & ~prev_reg.set;

    assign disp.hex3 = hex_reg[3];
    assign disp.hex2 = hex_reg[2];
    assign disp.hex1 = hex_reg[1];
    assign disp.hex0 = hex_reg[0];

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sync1_reg     <= '0;
            sync2_reg     <= '0;
            prev_reg      <= '0;
            snap_reg      <= '0;
            state_reg     <= IDLE;
            conv_cnt_reg  <= '0;
            bin_l_reg     <= '0;
            bin_r_reg     <= '0;
            bcd_l_reg     <= '0;
            bcd_r_reg     <= '0;
            blink_cnt_reg <= '0;
            hidden_reg    <= 1'b0;
            hex_reg       <= {4{SEG_BLANK}};
        end else begin
            sync1_reg     <= in_word;
            sync2_reg     <= sync1_reg;
            prev_reg      <= sync2_reg;
            snap_reg      <= snap_next;
            state_reg     <= state_next;
            conv_cnt_reg  <= conv_cnt_next;
            bin_l_reg     <= bin_l_next;
            bin_r_reg     <= bin_r_next;
            bcd_l_reg     <= bcd_l_next;
            bcd_r_reg     <= bcd_r_next;
            blink_cnt_reg <= blink_cnt_next;
            hidden_reg    <= hidden_next;
            hex_reg       <= hex_next;
        end
    end

    // A set rising edge restarts the blink so the edited field is visible first.
    always_comb begin
        blink_cnt_next = blink_cnt_reg + CW'(1);
        hidden_next    = hidden_reg;
        if (set_rise) begin
            blink_cnt_next = '0;
            hidden_next    = 1'b0;
        end else if (blink_cnt_reg == CW'(BLINK_HALF - 1)) begin
            blink_cnt_next = '0;
            hidden_next    = ~hidden_reg;
        end
    end

    always_comb begin
        left_bad    = snap_reg.page_sel ? (snap_reg.min > 6'd59) : (snap_reg.hour > 5'd23);
        right_bad   = snap_reg.page_sel ? (snap_reg.sec > 6'd59) : (snap_reg.min > 6'd59);
        left_blank  = snap_reg.set && hidden_reg &&
                      (snap_reg.sethms == (snap_reg.page_sel ? 2'b01 : 2'b00));
        right_blank = snap_reg.set && hidden_reg &&
                      (snap_reg.sethms == (snap_reg.page_sel ? 2'b10 : 2'b01));
    end

    always_comb begin
        state_next    = state_reg;
        conv_cnt_next = conv_cnt_reg;
        snap_next     = snap_reg;
        bin_l_next    = bin_l_reg;
        bin_r_next    = bin_r_reg;
        bcd_l_next    = bcd_l_reg;
        bcd_r_next    = bcd_r_reg;
        hex_next      = hex_reg;
        shift_l       = {dabble_adj(bcd_l_reg), bin_l_reg} << 1;
        shift_r       = {dabble_adj(bcd_r_reg), bin_r_reg} << 1;
        case (state_reg)
            IDLE: begin
                // Only an unchanged synced word is captured, so a counter mid-update never shows.
                if (stable) snap_next = sync2_reg;
                bin_l_next    = left_bin(snap_next);
                bin_r_next    = right_bin(snap_next);
                bcd_l_next    = '0;
                bcd_r_next    = '0;
                conv_cnt_next = '0;
                state_next    = CONV;
            end
            CONV: begin
                bcd_l_next    = shift_l[13:6];
                bin_l_next    = shift_l[5:0];
                bcd_r_next    = shift_r[13:6];
                bin_r_next    = shift_r[5:0];
                conv_cnt_next = conv_cnt_reg + 3'd1;
                if (conv_cnt_reg == 3'd5) state_next = LOAD;
            end
            LOAD: begin
                hex_next[3] = left_blank  ? SEG_BLANK : left_bad  ? SEG_DASH : seg7(bcd_l_reg[7:4]);
                hex_next[2] = left_blank  ? SEG_BLANK : left_bad  ? SEG_DASH : seg7(bcd_l_reg[3:0]);
                hex_next[1] = right_blank ? SEG_BLANK : right_bad ? SEG_DASH : seg7(bcd_r_reg[7:4]);
                hex_next[0] = right_blank ? SEG_BLANK : right_bad ? SEG_DASH : seg7(bcd_r_reg[3:0]);
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_clock_display.sv
// Scoreboard bench for clock_display: stimulus queues expected digit patterns, a monitor
// checks the settled display, blink cadence and absence of torn values.
module tb_clock_display;
    localparam int          BLINK      = 8;
    localparam int          SETTLE_WIN = 24;   // capture 3 + wait for IDLE 8 + refresh 7, with margin
    localparam logic [27:0] ALL_BLANK  = {4{7'h7F}};

    logic clk    = 1'b0;
    logic resetN = 1'b0;

    clock_display_if disp();

    clock_display #(.BLINK_HALF(BLINK)) dut (
        .clk    (clk),
        .resetN (resetN),
        .disp   (disp)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;      // 0 = settle to a value, 1 = blink cadence
        logic [27:0] vis;
        logic [27:0] alt;
        int          window;
        string       name;
    } item_t;

    item_t sb[$];
    int    total     = 0;
    int    bad       = 0;
    int    issued    = 0;
    int    completed = 0;

    logic [27:0] hex_all;
    assign hex_all = {disp.hex3, disp.hex2, disp.hex1, disp.hex0};

    // ---------------- reference model ----------------
    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            9:       return 7'b0010000;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [13:0] field_of(input int v, input int maxv, input bit blank);
        if (blank)    return {7'h7F, 7'h7F};
        if (v > maxv) return {7'b0111111, 7'b0111111};
        return {seg_of(v / 10), seg_of(v % 10)};
    endfunction

    function automatic logic [27:0] expect_of(input int h, input int m, input int s,
                                              input bit page, input bit bl, input bit br);
        if (!page) return {field_of(h, 23, bl), field_of(m, 59, br)};
        return {field_of(m, 59, bl), field_of(s, 59, br)};
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [27:0] act, input logic [27:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp_v);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic drive(input int h, input int m, input int s, input bit st,
                         input logic [1:0] hms, input bit pg);
        disp.hour    = h[4:0];
        disp.min     = m[5:0];
        disp.sec     = s[5:0];
        disp.set     = st;
        disp.sethms  = hms;
        disp.pageSel = pg;
    endtask

    task automatic push(input int kind, input logic [27:0] vis, input logic [27:0] alt,
                        input int win, input string name);
        item_t it;
        it.kind   = kind;
        it.vis    = vis;
        it.alt    = alt;
        it.window = win;
        it.name   = name;
        sb.push_back(it);
        issued++;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 400; i++) begin
            if (completed == issued) return;
            @(negedge clk);
        end
        $display("FAIL monitor_timeout: completed=%0d want %0d", completed, issued);
        $fatal(1, "monitor stalled");
    endtask

    // ---------------- monitor ----------------
    task automatic run_settle(input item_t it);
        logic [27:0] old_v, cur;
        bit          torn;
        int          tail_bad;
        old_v    = hex_all;
        cur      = hex_all;
        torn     = 1'b0;
        tail_bad = 0;
        for (int i = 0; i < it.window; i++) begin
            @(negedge clk);
            cur = hex_all;
            if (cur !== old_v && cur !== it.alt && cur !== it.vis) torn = 1'b1;
            if (i >= it.window - 3 && cur !== it.vis) tail_bad++;
        end
        total++;
        if (torn || tail_bad != 0) begin
            bad++;
            $display("FAIL %s: got %h want %h torn=%0d", it.name, cur, it.vis, torn);
        end else begin
            $display("ok   %s: %h", it.name, cur);
        end
    endtask

    task automatic run_blink(input item_t it);
        logic [27:0] seq [48];
        int first_bad, nvis, nhid, stray, last_t, nt, run_bad;
        first_bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (hex_all !== it.vis) first_bad++;
        end
        total++;
        if (first_bad != 0) begin
            bad++;
            $display("FAIL blink_visible_first: got %h want %h", hex_all, it.vis);
        end else begin
            $display("ok   blink_visible_first: %h", hex_all);
        end
        repeat (12) @(negedge clk);
        nvis = 0; nhid = 0; stray = 0;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            seq[i] = hex_all;
            if (seq[i] === it.vis)      nvis++;
            else if (seq[i] === it.alt) nhid++;
            else                        stray++;
        end
        total++;
        if (stray != 0 || nvis == 0 || nhid == 0) begin
            bad++;
            $display("FAIL blink_pattern: got vis=%0d hid=%0d stray=%0d want both seen, no stray",
                     nvis, nhid, stray);
        end else begin
            $display("ok   blink_pattern: vis=%0d hid=%0d", nvis, nhid);
        end
        last_t = -1; nt = 0; run_bad = 0;
        for (int i = 1; i < 48; i++) begin
            if (seq[i] !== seq[i-1]) begin
                if (last_t >= 0 && (i - last_t) != BLINK) run_bad++;
                last_t = i;
                nt++;
            end
        end
        total++;
        if (run_bad != 0 || nt < 3) begin
            bad++;
            $display("FAIL blink_period: got transitions=%0d bad_runs=%0d want runs of %0d",
                     nt, run_bad, BLINK);
        end else begin
            $display("ok   blink_period: transitions=%0d", nt);
        end
    endtask

    initial begin : monitor
        item_t it;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                it = sb.pop_front();
                if (it.kind == 1) run_blink(it);
                else              run_settle(it);
                completed++;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        logic [27:0] zero4, v1234, hid1234;
        int          h, m, s;
        bit          pg, st, off_page;
        logic [1:0]  hms;

        zero4   = expect_of(0, 0, 0, 1'b0, 1'b0, 1'b0);
        v1234   = expect_of(12, 34, 0, 1'b0, 1'b0, 1'b0);
        hid1234 = expect_of(12, 34, 0, 1'b0, 1'b1, 1'b0);

        drive(12, 34, 0, 1'b0, 2'b11, 1'b0);
        repeat (3) @(negedge clk);
        check("reset_blank", hex_all, ALL_BLANK);
        resetN = 1'b1;
        push(0, v1234, zero4, SETTLE_WIN, "reset_release_1234");
        wait_done();

        drive(12, 34, 0, 1'b1, 2'b00, 1'b0);
        push(1, v1234, hid1234, 0, "blink_hour_p0");
        wait_done();

        drive(12, 34, 0, 1'b1, 2'b10, 1'b0);
        push(0, v1234, hid1234, SETTLE_WIN, "sec_set_on_p0_no_blank");
        wait_done();

        drive(12, 34, 0, 1'b0, 2'b00, 1'b0);
        push(0, v1234, v1234, SETTLE_WIN, "set0_no_blank");
        wait_done();

        drive(12, 5, 9, 1'b0, 2'b11, 1'b1);
        push(0, expect_of(12, 5, 9, 1'b1, 1'b0, 1'b0), zero4, SETTLE_WIN, "p1_0509");
        wait_done();

        drive(12, 59, 59, 1'b0, 2'b11, 1'b1);
        push(0, expect_of(12, 59, 59, 1'b1, 1'b0, 1'b0), zero4, SETTLE_WIN, "p1_5959");
        wait_done();

        drive(12, 0, 0, 1'b0, 2'b11, 1'b1);
        push(0, zero4, zero4, SETTLE_WIN, "p1_0000");
        wait_done();

        // Word changes every cycle, so nothing but "0000" or the final value may appear.
        push(0, expect_of(12, 59, 58, 1'b1, 1'b0, 1'b0), zero4, 40, "rapid_then_5958");
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            drive(12, i, i, 1'b0, 2'b11, 1'b1);
        end
        @(negedge clk);
        drive(12, 59, 58, 1'b0, 2'b11, 1'b1);
        wait_done();

        drive(24, 7, 0, 1'b0, 2'b11, 1'b0);
        push(0, expect_of(24, 7, 0, 1'b0, 1'b0, 1'b0), zero4, SETTLE_WIN, "hour24_dash");
        wait_done();

        drive(12, 12, 60, 1'b0, 2'b11, 1'b1);
        push(0, expect_of(12, 12, 60, 1'b1, 1'b0, 1'b0), zero4, SETTLE_WIN, "sec60_dash");
        wait_done();

        for (int n = 0; n < 20; n++) begin
            h   = $urandom_range(0, 31);
            m   = $urandom_range(0, 63);
            s   = $urandom_range(0, 63);
            pg  = 1'($urandom_range(0, 1));
            hms = 2'($urandom_range(0, 3));
            off_page = pg ? !(hms == 2'b01 || hms == 2'b10) : !(hms == 2'b00 || hms == 2'b01);
            st  = off_page ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            drive(h, m, s, st, hms, pg);
            push(0, expect_of(h, m, s, pg, 1'b0, 1'b0), expect_of(h, m, s, pg, 1'b0, 1'b0),
                 SETTLE_WIN, "random");
            wait_done();
        end

        for (int off = 0; off < 8; off++) begin
            h = $urandom_range(0, 23);
            m = $urandom_range(0, 59);
            @(negedge clk);
            drive(h, m, 0, 1'b0, 2'b11, 1'b0);
            repeat (off + 4) @(posedge clk);
            #2 resetN = 1'b0;
            #1 check("reset_async_blank", hex_all, ALL_BLANK);
            @(negedge clk);
            @(negedge clk);
            resetN = 1'b1;
            push(0, expect_of(h, m, 0, 1'b0, 1'b0, 1'b0), zero4, SETTLE_WIN, "reset_recover");
            wait_done();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "simulation time limit");
    end
endmodule
